// File: rtl/vga_window_mixer.sv
// Pixel compositor: NUM_WIN prioritised rectangles over a solid or LFSR-noise
// background, with frame-synchronous shadow-to-active configuration commit.
module vga_window_mixer #(
  parameter int          NUM_WIN   = 4,
  parameter int          COORD_W   = 13,
  parameter int          WIN_IDX_W = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic        SYNC_IDLE = 1'b1
) (
  input  logic                   PIXEL_CLK,
  input  logic                   RST_N,
  input  logic [COORD_W-1:0]     locX,
  input  logic [COORD_W-1:0]     locY,
  input  logic                   in_image,
  input  logic                   sync_h_in,
  input  logic                   sync_v_in,
  input  logic                   frame_start,
  input  logic                   cfg_we,
  input  logic [WIN_IDX_W+2:0]   cfg_addr,
  input  logic [COORD_W-1:0]     cfg_data,
  output logic                   cfg_pending,
  output logic [2:0]             vgaRed,
  output logic [2:0]             vgaGreen,
  output logic [1:0]             vgaBlue,
  output logic                   Hsync,
  output logic                   Vsync
);

  // An all-zero Galois state is a lock-up point, so a zero seed is remapped.
  localparam logic [15:0] SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  logic [2:0]           field;
  logic [WIN_IDX_W-1:0] widx;
  logic                 win_ok;
  logic                 wr_win;
  logic                 wr_bg;
  logic                 pending_d, pending_q;

  logic [COORD_W-1:0] sh_xlo_q [NUM_WIN];
  logic [COORD_W-1:0] sh_xhi_q [NUM_WIN];
  logic [COORD_W-1:0] sh_ylo_q [NUM_WIN];
  logic [COORD_W-1:0] sh_yhi_q [NUM_WIN];
  logic [7:0]         sh_col_q [NUM_WIN];
  logic [NUM_WIN-1:0] sh_en_q;
  logic [7:0]         sh_bg_q;
  logic               sh_noise_q;

  logic [COORD_W-1:0] sh_xlo_d [NUM_WIN];
  logic [COORD_W-1:0] sh_xhi_d [NUM_WIN];
  logic [COORD_W-1:0] sh_ylo_d [NUM_WIN];
  logic [COORD_W-1:0] sh_yhi_d [NUM_WIN];
  logic [7:0]         sh_col_d [NUM_WIN];
  logic [NUM_WIN-1:0] sh_en_d;
  logic [7:0]         sh_bg_d;
  logic               sh_noise_d;

  logic [COORD_W-1:0] act_xlo_q [NUM_WIN];
  logic [COORD_W-1:0] act_xhi_q [NUM_WIN];
  logic [COORD_W-1:0] act_ylo_q [NUM_WIN];
  logic [COORD_W-1:0] act_yhi_q [NUM_WIN];
  logic [7:0]         act_col_q [NUM_WIN];
  logic [NUM_WIN-1:0] act_en_q;
  logic [7:0]         act_bg_q;
  logic               act_noise_q;

  logic [15:0]        lfsr_d, lfsr_q;
  logic [NUM_WIN-1:0] hit_d;
  logic [NUM_WIN-1:0] s1_hit_q;
  logic               s1_img_q;
  logic [7:0]         s1_noise_q;
  logic               s1_hs_q, s1_vs_q;
  logic [7:0]         colour_d, colour_q;
  logic               s2_hs_q, s2_vs_q;

  assign field  = cfg_addr[2:0];
  assign widx   = cfg_addr[WIN_IDX_W+2:3];
  assign win_ok = (int'(widx) < NUM_WIN);
  assign wr_win = cfg_we && win_ok && (field <= 3'd5);
  assign wr_bg  = cfg_we && (field == 3'd7);

  // A write in the same cycle as a commit must leave the flag set.
  assign pending_d = (wr_win || wr_bg) ? 1'b1 :
                     frame_start       ? 1'b0 : pending_q;

  always_comb begin
    sh_xlo_d   = sh_xlo_q;
    sh_xhi_d   = sh_xhi_q;
    sh_ylo_d   = sh_ylo_q;
    sh_yhi_d   = sh_yhi_q;
    sh_col_d   = sh_col_q;
    sh_en_d    = sh_en_q;
    sh_bg_d    = sh_bg_q;
    sh_noise_d = sh_noise_q;
    for (int w = 0; w < NUM_WIN; w++) begin
      if (wr_win && (int'(widx) == w)) begin
        case (field)
          3'd0:    sh_xlo_d[w] = cfg_data;
          3'd1:    sh_xhi_d[w] = cfg_data;
          3'd2:    sh_ylo_d[w] = cfg_data;
          3'd3:    sh_yhi_d[w] = cfg_data;
          3'd4:    sh_col_d[w] = cfg_data[7:0];
          3'd5:    sh_en_d[w]  = cfg_data[0];
          default: ;
        endcase
      end
    end
    if (wr_bg) begin
      sh_bg_d    = cfg_data[7:0];
      sh_noise_d = cfg_data[8];
    end
  end

  // The commit copies the shadow as it stood before any same-cycle write.
  always_ff @(posedge PIXEL_CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int w = 0; w < NUM_WIN; w++) begin
        sh_xlo_q[w]  <= '0;
        sh_xhi_q[w]  <= '0;
        sh_ylo_q[w]  <= '0;
        sh_yhi_q[w]  <= '0;
        sh_col_q[w]  <= '0;
        act_xlo_q[w] <= '0;
        act_xhi_q[w] <= '0;
        act_ylo_q[w] <= '0;
        act_yhi_q[w] <= '0;
        act_col_q[w] <= '0;
      end
      sh_en_q     <= '0;
      act_en_q    <= '0;
      sh_bg_q     <= '0;
      act_bg_q    <= '0;
      sh_noise_q  <= 1'b1;
      act_noise_q <= 1'b1;
      pending_q   <= 1'b0;
    end else begin
      sh_xlo_q   <= sh_xlo_d;
      sh_xhi_q   <= sh_xhi_d;
      sh_ylo_q   <= sh_ylo_d;
      sh_yhi_q   <= sh_yhi_d;
      sh_col_q   <= sh_col_d;
      sh_en_q    <= sh_en_d;
      sh_bg_q    <= sh_bg_d;
      sh_noise_q <= sh_noise_d;
      if (frame_start) begin
        act_xlo_q   <= sh_xlo_q;
        act_xhi_q   <= sh_xhi_q;
        act_ylo_q   <= sh_ylo_q;
        act_yhi_q   <= sh_yhi_q;
        act_col_q   <= sh_col_q;
        act_en_q    <= sh_en_q;
        act_bg_q    <= sh_bg_q;
        act_noise_q <= sh_noise_q;
      end
      pending_q <= pending_d;
    end
  end

  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);

  // Half-open bounds, so lo >= hi can never match.
  always_comb begin
    hit_d = '0;
    for (int w = 0; w < NUM_WIN; w++) begin
      hit_d[w] = act_en_q[w] &&
                 (locX >= act_xlo_q[w]) && (locX < act_xhi_q[w]) &&
                 (locY >= act_ylo_q[w]) && (locY < act_yhi_q[w]);
    end
  end

  always_ff @(posedge PIXEL_CLK or negedge RST_N) begin
    if (!RST_N) begin
      lfsr_q     <= SEED;
      s1_hit_q   <= '0;
      s1_img_q   <= 1'b0;
      s1_noise_q <= '0;
      s1_hs_q    <= SYNC_IDLE;
      s1_vs_q    <= SYNC_IDLE;
    end else begin
      lfsr_q     <= lfsr_d;
      s1_hit_q   <= hit_d;
      s1_img_q   <= in_image;
      s1_noise_q <= lfsr_q[7:0];
      s1_hs_q    <= sync_h_in;
      s1_vs_q    <= sync_v_in;
    end
  end

  // Scanning from the highest index down leaves the lowest-index hit in place.
  always_comb begin
    colour_d = '0;
    if (s1_img_q) begin
      colour_d = act_noise_q ? s1_noise_q : act_bg_q;
      for (int w = NUM_WIN - 1; w >= 0; w--) begin
        if (s1_hit_q[w]) colour_d = act_col_q[w];
      end
    end
  end

  always_ff @(posedge PIXEL_CLK or negedge RST_N) begin
    if (!RST_N) begin
      colour_q <= '0;
      s2_hs_q  <= SYNC_IDLE;
      s2_vs_q  <= SYNC_IDLE;
    end else begin
      colour_q <= colour_d;
      s2_hs_q  <= s1_hs_q;
      s2_vs_q  <= s1_vs_q;
    end
  end

  assign cfg_pending = pending_q;
  assign vgaRed      = colour_q[2:0];
  assign vgaGreen    = colour_q[5:3];
  assign vgaBlue     = colour_q[7:6];
  assign Hsync       = s2_hs_q;
  assign Vsync       = s2_vs_q;

endmodule

// File: tb/tb_vga_window_mixer.sv
// Self-checking bench for vga_window_mixer: directed scenarios plus random
// traffic, compared every cycle against a frame-level behavioural model.
module tb_vga_window_mixer;

  localparam int          NUM_WIN   = 4;
  localparam int          COORD_W   = 13;
  localparam int          WIN_IDX_W = 3;
  localparam logic [15:0] SEED      = 16'h0001;

  logic                 PIXEL_CLK = 1'b0;
  logic                 RST_N     = 1'b1;
  logic [COORD_W-1:0]   locX = '0, locY = '0;
  logic                 in_image = 1'b0, sync_h_in = 1'b1, sync_v_in = 1'b1;
  logic                 frame_start = 1'b0, cfg_we = 1'b0;
  logic [WIN_IDX_W+2:0] cfg_addr = '0;
  logic [COORD_W-1:0]   cfg_data = '0;
  logic                 cfg_pending, Hsync, Vsync;
  logic [2:0]           vgaRed, vgaGreen;
  logic [1:0]           vgaBlue;

  int checks   = 0;
  int failures = 0;

  vga_window_mixer #(
    .NUM_WIN(NUM_WIN), .COORD_W(COORD_W), .WIN_IDX_W(WIN_IDX_W),
    .LFSR_SEED(SEED), .SYNC_IDLE(1'b1)
  ) dut (
    .PIXEL_CLK(PIXEL_CLK), .RST_N(RST_N), .locX(locX), .locY(locY),
    .in_image(in_image), .sync_h_in(sync_h_in), .sync_v_in(sync_v_in),
    .frame_start(frame_start), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_pending(cfg_pending), .vgaRed(vgaRed),
    .vgaGreen(vgaGreen), .vgaBlue(vgaBlue), .Hsync(Hsync), .Vsync(Vsync)
  );

  always #5 PIXEL_CLK = ~PIXEL_CLK;

  // Reference model: shadow/active configuration as plain arrays, colour from
  // the priority rule, and a 2-entry delay line for the output latency.
  logic [12:0] mShXlo [NUM_WIN], mShXhi [NUM_WIN], mShYlo [NUM_WIN], mShYhi [NUM_WIN];
  logic [12:0] mAcXlo [NUM_WIN], mAcXhi [NUM_WIN], mAcYlo [NUM_WIN], mAcYhi [NUM_WIN];
  logic [7:0]  mShCol [NUM_WIN], mAcCol [NUM_WIN];
  bit          mShEn  [NUM_WIN], mAcEn  [NUM_WIN];
  logic [7:0]  mShBg, mAcBg;
  bit          mShNoise, mAcNoise, mPend;
  logic [15:0] mLfsr;
  logic [9:0]  mS1, mOut;
  logic [2:0]  mField;
  int          mIdx;

  function automatic logic [15:0] lfsrStep(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic logic [7:0] pickColour(input logic [12:0] x, input logic [12:0] y,
                                            input bit img);
    if (!img) return 8'h00;
    for (int w = 0; w < NUM_WIN; w++)
      if (mAcEn[w] && x >= mAcXlo[w] && x < mAcXhi[w] && y >= mAcYlo[w] && y < mAcYhi[w])
        return mAcCol[w];
    return mAcNoise ? mLfsr[7:0] : mAcBg;
  endfunction

  always @(posedge PIXEL_CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int w = 0; w < NUM_WIN; w++) begin
        mShXlo[w] = 0; mShXhi[w] = 0; mShYlo[w] = 0; mShYhi[w] = 0; mShCol[w] = 0; mShEn[w] = 0;
        mAcXlo[w] = 0; mAcXhi[w] = 0; mAcYlo[w] = 0; mAcYhi[w] = 0; mAcCol[w] = 0; mAcEn[w] = 0;
      end
      mShBg = 0; mAcBg = 0; mShNoise = 1; mAcNoise = 1; mPend = 0;
      mLfsr = (SEED == 16'h0000) ? 16'h0001 : SEED;
      mS1   = {8'h00, 2'b11};
      mOut  = {8'h00, 2'b11};
    end else begin
      mOut = mS1;
      mS1  = {pickColour(locX, locY, in_image), sync_h_in, sync_v_in};
      if (frame_start) begin
        mAcXlo = mShXlo; mAcXhi = mShXhi; mAcYlo = mShYlo; mAcYhi = mShYhi;
        mAcCol = mShCol; mAcEn = mShEn; mAcBg = mShBg; mAcNoise = mShNoise;
        mPend  = 0;
      end
      if (cfg_we) begin
        mField = cfg_addr[2:0];
        mIdx   = int'(cfg_addr[5:3]);
        if (mField == 3'd7) begin
          mShBg = cfg_data[7:0]; mShNoise = cfg_data[8]; mPend = 1;
        end else if (mField != 3'd6 && mIdx < NUM_WIN) begin
          case (mField)
            3'd0: mShXlo[mIdx] = cfg_data;
            3'd1: mShXhi[mIdx] = cfg_data;
            3'd2: mShYlo[mIdx] = cfg_data;
            3'd3: mShYhi[mIdx] = cfg_data;
            3'd4: mShCol[mIdx] = cfg_data[7:0];
            default: mShEn[mIdx] = cfg_data[0];
          endcase
          mPend = 1;
        end
      end
      mLfsr = lfsrStep(mLfsr);
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge PIXEL_CLK) begin
    if (RST_N) begin
      checkOutput("rgb",     16'({vgaBlue, vgaGreen, vgaRed}), 16'(mOut[9:2]));
      checkOutput("hsync",   16'(Hsync),       16'(mOut[1]));
      checkOutput("vsync",   16'(Vsync),       16'(mOut[0]));
      checkOutput("pending", 16'(cfg_pending), 16'(mPend));
    end
  end

  task automatic applyStimulus(input logic [12:0] x, input logic [12:0] y, input bit img,
                               input bit fs, input bit we, input logic [5:0] addr,
                               input logic [12:0] data);
    @(negedge PIXEL_CLK);
    locX = x; locY = y; in_image = img; frame_start = fs;
    cfg_we = we; cfg_addr = addr; cfg_data = data;
    sync_h_in = 1'($urandom_range(0, 1));
    sync_v_in = 1'($urandom_range(0, 1));
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic commit();
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
  endtask

  task automatic cfgWrite(input int idx, input int field, input logic [12:0] data);
    applyStimulus(0, 0, 0, 0, 1, {3'(idx), 3'(field)}, data);
  endtask

  task automatic pixelCheck(input string name, input logic [12:0] x, input logic [12:0] y,
                            input logic [7:0] exp);
    idle();
    applyStimulus(x, y, 1, 0, 0, 0, 0);
    idle();
    checkOutput({name, "_early"}, 16'({vgaBlue, vgaGreen, vgaRed}), 16'h0000);
    idle();
    checkOutput(name, 16'({vgaBlue, vgaGreen, vgaRed}), 16'(exp));
  endtask

  initial begin
    checkOutput("model_lfsr_step0", lfsrStep(16'h0001), 16'hB400);
    checkOutput("model_lfsr_step1", lfsrStep(16'hB400), 16'h5A00);

    sync_h_in = 0; sync_v_in = 0;
    #1 RST_N = 1'b0;
    repeat (3) @(negedge PIXEL_CLK);
    checkOutput("reset_rgb",     16'({vgaBlue, vgaGreen, vgaRed}), 16'h0000);
    checkOutput("reset_hsync",   16'(Hsync), 16'h0001);
    checkOutput("reset_vsync",   16'(Vsync), 16'h0001);
    checkOutput("reset_pending", 16'(cfg_pending), 16'h0000);
    @(negedge PIXEL_CLK) RST_N = 1'b1;

    $display("[TB] Background solid black");
    cfgWrite(0, 7, 13'h000);
    commit();
    repeat (5) applyStimulus(13'd10, 13'd10, 1, 0, 0, 0, 0);
    idle();
    checkOutput("bg_black_rgb", 16'({vgaBlue, vgaGreen, vgaRed}), 16'h0000);
    checkOutput("bg_black_pending", 16'(cfg_pending), 16'h0000);

    $display("[TB] Single window");
    cfgWrite(0, 0, 13'd50);  cfgWrite(0, 1, 13'd100);
    cfgWrite(0, 2, 13'd100); cfgWrite(0, 3, 13'd200);
    cfgWrite(0, 4, 13'h1E5); cfgWrite(0, 5, 13'h001);
    cfgWrite(0, 7, 13'h012);
    commit();
    pixelCheck("w0_corner",  13'd50,  13'd100, 8'hE5);
    pixelCheck("w0_x_hi",    13'd100, 13'd100, 8'h12);
    pixelCheck("w0_y_hi",    13'd60,  13'd200, 8'h12);
    pixelCheck("w0_inner",   13'd99,  13'd199, 8'hE5);

    $display("[TB] Overlapping windows");
    cfgWrite(0, 4, 13'h007);
    cfgWrite(1, 0, 13'd80);  cfgWrite(1, 1, 13'd150);
    cfgWrite(1, 2, 13'd150); cfgWrite(1, 3, 13'd250);
    cfgWrite(1, 4, 13'h0C0); cfgWrite(1, 5, 13'h001);
    commit();
    pixelCheck("overlap_w0", 13'd90, 13'd160, 8'h07);
    cfgWrite(0, 5, 13'h000);
    commit();
    pixelCheck("overlap_w1", 13'd90, 13'd160, 8'hC0);

    $display("[TB] Shadow commit timing");
    cfgWrite(1, 4, 13'h01C);
    pixelCheck("midframe_unchanged", 13'd90, 13'd160, 8'hC0);
    checkOutput("midframe_pending", 16'(cfg_pending), 16'h0001);
    commit();
    idle();
    checkOutput("commit_clears_pending", 16'(cfg_pending), 16'h0000);
    pixelCheck("commit_new_colour", 13'd90, 13'd160, 8'h1C);
    applyStimulus(0, 0, 0, 1, 1, {3'd1, 3'd4}, 13'h03F);
    idle();
    checkOutput("coincident_pending", 16'(cfg_pending), 16'h0001);
    pixelCheck("coincident_pre_write", 13'd90, 13'd160, 8'h1C);
    commit();
    pixelCheck("coincident_post", 13'd90, 13'd160, 8'h3F);

    $display("[TB] Noise background");
    cfgWrite(1, 5, 13'h000);
    cfgWrite(0, 7, 13'h100);
    commit();
    for (int i = 0; i < 40; i++)
      applyStimulus(13'($urandom_range(0, 300)), 13'($urandom_range(0, 300)),
                    (i % 7) != 3, 0, 0, 0, 0);

    $display("[TB] Out-of-range window index");
    cfgWrite(5, 0, 13'd7);
    idle();
    checkOutput("bad_index_pending", 16'(cfg_pending), 16'h0000);

    $display("[TB] Random traffic");
    for (int i = 0; i < 800; i++) begin
      bit          fs, img, we;
      int          fld;
      logic [12:0] d;
      fs  = ($urandom_range(0, 39) == 0);
      img = fs ? 1'b0 : ($urandom_range(0, 3) != 0);
      we  = ($urandom_range(0, 4) == 0);
      fld = $urandom_range(0, 6);
      if (fld == 6) fld = 7;
      d = (fld <= 3) ? 13'($urandom_range(0, 300)) : 13'($urandom);
      applyStimulus(13'($urandom_range(0, 320)), 13'($urandom_range(0, 320)), img, fs, we,
                    {3'($urandom_range(0, 7)), 3'(fld)}, d);
    end

    $display("[TB] Asynchronous reset");
    cfgWrite(0, 0, 13'd50);  cfgWrite(0, 1, 13'd100);
    cfgWrite(0, 2, 13'd100); cfgWrite(0, 3, 13'd200);
    cfgWrite(0, 4, 13'h0E5); cfgWrite(0, 5, 13'h001);
    commit();
    cfgWrite(2, 4, 13'h001);
    applyStimulus(13'd60, 13'd120, 1, 0, 0, 0, 0);
    applyStimulus(13'd60, 13'd120, 1, 0, 0, 0, 0);
    sync_h_in = 0; sync_v_in = 0;
    repeat (2) @(negedge PIXEL_CLK);
    checkOutput("pre_reset_rgb",     16'({vgaBlue, vgaGreen, vgaRed}), 16'h00E5);
    checkOutput("pre_reset_hsync",   16'(Hsync), 16'h0000);
    checkOutput("pre_reset_pending", 16'(cfg_pending), 16'h0001);
    #2 RST_N = 1'b0;
    #1;
    checkOutput("async_reset_rgb",     16'({vgaBlue, vgaGreen, vgaRed}), 16'h0000);
    checkOutput("async_reset_hsync",   16'(Hsync), 16'h0001);
    checkOutput("async_reset_vsync",   16'(Vsync), 16'h0001);
    checkOutput("async_reset_pending", 16'(cfg_pending), 16'h0000);
    repeat (2) @(negedge PIXEL_CLK);
    RST_N = 1'b1;
    repeat (6) applyStimulus(13'd60, 13'd120, 1, 0, 0, 0, 0);
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_window_mixer.md
Name: vga_window_mixer

Overview:
Parametrised pixel compositor for the VGA pipeline. It replaces the single hard-coded middle box with NUM_WIN programmable rectangles, each with its own colour, over a selectable background of solid colour or LFSR noise. It sits between vga_sync and the RGB pins and is clocked by the pixel clock. Configuration writes go to shadow registers and become visible only at frame boundaries, so the image never tears.

Parameters:
NUM_WIN, 4, number of rectangles; range 1..8; index 0 has the highest priority.
COORD_W, 13, width of locX/locY and of the window bound registers.
WIN_IDX_W, 3, window-index field width of cfg_addr; must satisfy 2^WIN_IDX_W >= NUM_WIN.
LFSR_SEED, 16'hACE1, reset value of the noise LFSR; 0 is replaced by 16'h0001.
SYNC_IDLE, 1, reset value driven on Hsync/Vsync.

Ports:
PIXEL_CLK  in  1  pixel clock.
RST_N  in  1  asynchronous active-low reset.
locX  in  COORD_W  current pixel X from vga_sync.
locY  in  COORD_W  current pixel Y from vga_sync.
in_image  in  1  high in the visible area.
sync_h_in  in  1  raw horizontal sync from vga_sync.
sync_v_in  in  1  raw vertical sync from vga_sync.
frame_start  in  1  single-cycle pulse once per frame, during blanking.
cfg_we  in  1  configuration write strobe.
cfg_addr  in  WIN_IDX_W+3  {window index, field[2:0]}.
cfg_data  in  COORD_W  write data.
cfg_pending  out  1  high while the shadow registers hold uncommitted writes.
vgaRed  out  3  red output.
vgaGreen  out  3  green output.
vgaBlue  out  2  blue output.
Hsync  out  1  sync_h_in delayed to align with the RGB outputs.
Vsync  out  1  sync_v_in delayed to align with the RGB outputs.

Behaviour:
- Reset (async assert, sync release):
  - RGB outputs 0; Hsync/Vsync = SYNC_IDLE; cfg_pending 0.
  - All shadow and active window registers 0, all windows disabled.
  - Background register: noise_en=1, bg_color=0. LFSR = seed.
- Config fields (per window, stored in shadow):
  - 0 x_lo, 1 x_hi, 2 y_lo, 3 y_hi (full COORD_W).
  - 4 colour: data[7:0] = {B[1:0], G[2:0], R[2:0]}.
  - 5 control: data[0] = enable.
  - 6: reserved, write ignored.
  - 7: global background, window index ignored; data[7:0] = bg_color, data[8] = noise_en.
- Write address rules:
  - A write to a window index >= NUM_WIN with field 0..6 is ignored and does not set cfg_pending.
  - Unused upper bits of cfg_data are ignored.
- Commit:
  - On a cycle with frame_start=1, all active registers <= shadow, then cfg_pending <= 0.
  - Any accepted write sets cfg_pending <= 1.
  - If cfg_we and frame_start coincide: the commit uses the pre-write shadow, the write lands in shadow, and cfg_pending ends at 1.
- Hit test: window w hits when enable && x_lo <= locX < x_hi && y_lo <= locY < y_hi (unsigned). lo >= hi means the window never hits.
- Pipeline (latency exactly 2 PIXEL_CLK from inputs to outputs):
  - S1 registers the hit vector, in_image, the LFSR byte and the syncs.
  - S2 registers the final colour and the syncs.
- Colour select at S2, in priority order:
  - !in_image -> 0.
  - Else the lowest-index hitting window -> its colour.
  - Else noise_en ? LFSR[7:0] : bg_color.
- Noise LFSR: 16-bit Galois, mask 16'hB400. Shifts every cycle, including blanking. Never reaches 0.
- Active registers are used only by the pipeline; a write mid-frame has no visible effect until the next frame_start.

Test Plan:
1. Reset, then 5 cycles with in_image=1 and noise_en cleared via a committed field-7 write of 0 -> RGB = 0, Hsync=Vsync=1 during reset, cfg_pending=0.
2. Window 0 = x 50..100, y 100..200, colour 8'hE5, enabled, followed by a frame_start pulse:
   - pixel (50,100) -> R=5, G=4, B=3 exactly 2 cycles after the inputs.
   - pixel (100,100) -> background.
3. Windows 0 and 1 overlap with colours 8'h07 and 8'hC0; pixel in the overlap -> R=7, G=0, B=0. After disabling window 0 and committing -> R=0, G=0, B=3.
4. Write a window mid-frame without frame_start -> output unchanged and cfg_pending=1. Pulse frame_start -> new colour takes effect and cfg_pending=0. Write coincident with frame_start -> cfg_pending stays 1.
5. noise_en=1, LFSR_SEED=16'h0001, in_image=1, no hits -> the output sequence matches the Galois 0xB400 reference model; in_image=0 forces 0 regardless.
6. Write to window index 5 with NUM_WIN=4 -> ignored and cfg_pending stays 0. Assert RST_N mid-frame -> outputs go to reset values immediately, asynchronously.
